// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit bit sequencer: opening flag, buffered payload, FCS, closing flag,
// with zero insertion over payload/FCS and an abort pattern on request.
module hdlc_tx_sequencer #(
    parameter int MAX_BYTES  = 128,
    parameter int ABORT_ONES = 7
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tx_Enable,
    input  logic        Tx_AbortFrame,
    input  logic        Tx_DataAvail,
    input  logic [7:0]  Tx_FrameSize,
    output logic        Tx_RdBuff,
    input  logic [7:0]  Tx_DataOutBuff,
    output logic        Fcs_Clear,
    output logic        Fcs_Shift,
    output logic        Fcs_BitIn,
    input  logic [15:0] Fcs_Value,
    output logic        Tx,
    output logic        Tx_ValidFrame,
    output logic        Tx_Done,
    output logic        Tx_AbortedTrans
);

    localparam int IDX_W = (ABORT_ONES > 15) ? $clog2(ABORT_ONES + 1) : 4;
    localparam logic [7:0] FLAG = 8'h7E;

    typedef enum logic [2:0] {IDLE, FLAG_S, DATA, FCS, FLAG_E, ABORT} state_t;

    // The registered state always describes the bit currently on Tx; the
    // combinational block decides the bit for the next cycle.
    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic             stuffed, stuffed_n;
    logic [2:0]       ones, ones_n;
    logic [7:0]       byte_cnt, byte_n, byte_inc;
    logic [7:0]       size_q, size_n;
    logic [7:0]       cur_byte, cur_n;
    logic [7:0]       hold;
    logic [15:0]      fcs_q, fcs_n;
    logic             rd_q;
    logic             tx_n, valid_n, done_n, rd_n, clr_n, shift_n, aborted_n;
    logic             start, in_frame, last_flag, abort_req;

    assign idx_inc  = idx + IDX_W'(1);
    assign byte_inc = byte_cnt + 8'd1;

    assign start = Tx_Enable && Tx_DataAvail && !Tx_AbortFrame &&
                   (Tx_FrameSize != 8'd0) && ({24'd0, Tx_FrameSize} <= 32'(MAX_BYTES));

    assign in_frame  = (state == FLAG_S) || (state == DATA) || (state == FCS) || (state == FLAG_E);
    assign last_flag = (state == FLAG_E) && (idx[2:0] == 3'd7);
    assign abort_req = in_frame && Tx_ValidFrame && Tx_AbortFrame && !last_flag;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        stuffed_n = 1'b0;
        ones_n    = 3'd0;
        byte_n    = byte_cnt;
        size_n    = size_q;
        cur_n     = cur_byte;
        fcs_n     = fcs_q;
        tx_n      = 1'b1;
        valid_n   = 1'b0;
        done_n    = 1'b0;
        rd_n      = 1'b0;
        clr_n     = 1'b0;
        shift_n   = 1'b0;
        aborted_n = Tx_AbortedTrans;

        if (abort_req) begin
            state_n   = ABORT;
            idx_n     = '0;
            tx_n      = 1'b0;
            aborted_n = 1'b1;
        end else if ((state == DATA || state == FCS) && !stuffed && ones == 3'd5) begin
            // Inserted zero: position is held so the next real bit resumes in place.
            stuffed_n = 1'b1;
            tx_n      = 1'b0;
            valid_n   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n   = FLAG_S;
                        idx_n     = '0;
                        size_n    = Tx_FrameSize;
                        tx_n      = FLAG[0];
                        valid_n   = 1'b1;
                        rd_n      = 1'b1;
                        clr_n     = 1'b1;
                        aborted_n = 1'b0;
                    end
                end
                FLAG_S: begin
                    valid_n = 1'b1;
                    if (idx[2:0] != 3'd7) begin
                        idx_n = idx_inc;
                        tx_n  = FLAG[idx_inc[2:0]];
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                        byte_n  = 8'd0;
                        cur_n   = hold;
                        tx_n    = hold[0];
                        shift_n = 1'b1;
                        ones_n  = hold[0] ? 3'd1 : 3'd0;
                        rd_n    = (size_q > 8'd1);
                    end
                end
                DATA: begin
                    valid_n = 1'b1;
                    if (idx[2:0] != 3'd7) begin
                        idx_n   = idx_inc;
                        tx_n    = cur_byte[idx_inc[2:0]];
                        shift_n = 1'b1;
                        ones_n  = tx_n ? ones + 3'd1 : 3'd0;
                    end else if (byte_inc < size_q) begin
                        byte_n  = byte_inc;
                        idx_n   = '0;
                        cur_n   = hold;
                        tx_n    = hold[0];
                        shift_n = 1'b1;
                        ones_n  = tx_n ? ones + 3'd1 : 3'd0;
                        rd_n    = (byte_inc < size_q - 8'd1);
                    end else begin
                        // Last Fcs_Shift was issued in an earlier cycle, so Fcs_Value is settled.
                        state_n = FCS;
                        idx_n   = '0;
                        fcs_n   = Fcs_Value;
                        tx_n    = Fcs_Value[0];
                        ones_n  = tx_n ? ones + 3'd1 : 3'd0;
                    end
                end
                FCS: begin
                    valid_n = 1'b1;
                    if (idx != IDX_W'(15)) begin
                        idx_n  = idx_inc;
                        tx_n   = fcs_q[idx_inc[3:0]];
                        ones_n = tx_n ? ones + 3'd1 : 3'd0;
                    end else begin
                        state_n = FLAG_E;
                        idx_n   = '0;
                        tx_n    = FLAG[0];
                    end
                end
                FLAG_E: begin
                    if (idx[2:0] != 3'd7) begin
                        idx_n   = idx_inc;
                        tx_n    = FLAG[idx_inc[2:0]];
                        valid_n = 1'b1;
                        done_n  = (idx_inc[2:0] == 3'd7);
                    end else begin
                        state_n = IDLE;
                    end
                end
                ABORT: begin
                    if (idx != IDX_W'(ABORT_ONES)) idx_n = idx_inc;
                    else                           state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FCS strobes lead Tx by one cycle so the CRC is ready right after the last data bit.
    assign Fcs_Shift = shift_n & ~Rst;
    assign Fcs_BitIn = shift_n & tx_n & ~Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= IDLE;
            idx             <= '0;
            stuffed         <= 1'b0;
            ones            <= 3'd0;
            byte_cnt        <= 8'd0;
            size_q          <= 8'd0;
            cur_byte        <= 8'd0;
            hold            <= 8'd0;
            fcs_q           <= 16'd0;
            rd_q            <= 1'b0;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_RdBuff       <= 1'b0;
            Fcs_Clear       <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            stuffed         <= stuffed_n;
            ones            <= ones_n;
            byte_cnt        <= byte_n;
            size_q          <= size_n;
            cur_byte        <= cur_n;
            fcs_q           <= fcs_n;
            rd_q            <= Tx_RdBuff;
            if (rd_q) hold  <= Tx_DataOutBuff;
            Tx              <= tx_n;
            Tx_ValidFrame   <= valid_n;
            Tx_Done         <= done_n;
            Tx_RdBuff       <= rd_n;
            Fcs_Clear       <= clr_n;
            Tx_AbortedTrans <= aborted_n;
        end
    end

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Directed bench for hdlc_tx_sequencer: frames, stuffing, abort, reject, reset.
module tb_hdlc_tx_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, Tx_Enable, Tx_AbortFrame, Tx_DataAvail;
    logic [7:0]  Tx_FrameSize, Tx_DataOutBuff;
    logic [15:0] Fcs_Value;
    logic        Tx_RdBuff, Fcs_Clear, Fcs_Shift, Fcs_BitIn;
    logic        Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;

    hdlc_tx_sequencer #(.MAX_BYTES(128), .ABORT_ONES(7)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
        .Tx_DataAvail(Tx_DataAvail), .Tx_FrameSize(Tx_FrameSize), .Tx_RdBuff(Tx_RdBuff),
        .Tx_DataOutBuff(Tx_DataOutBuff), .Fcs_Clear(Fcs_Clear), .Fcs_Shift(Fcs_Shift),
        .Fcs_BitIn(Fcs_BitIn), .Fcs_Value(Fcs_Value), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
        .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  buf_mem [0:7];
    logic [63:0] cap_tx, cap_vld, cap_abt, cap_sh;
    logic [7:0]  cap_snap;
    int          cap_rd, cap_shn, cap_clr, cap_done, done_at;

    // Pulses Tx_Enable, then records n_cyc cycles; cycle 1 is the first cycle after the sampling edge.
    task automatic run(input int size, input int n_cyc, input int abort_at,
                       input int enable_at, input int rst_at);
        int ptr;
        ptr = 0;
        cap_tx = '0; cap_vld = '0; cap_abt = '0; cap_sh = '0; cap_snap = '0;
        cap_rd = 0; cap_shn = 0; cap_clr = 0; cap_done = 0; done_at = 0;
        @(negedge Clk);
        Tx_FrameSize = 8'(size);
        Tx_Enable    = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge Clk);
            Tx_Enable     = (c == enable_at);
            Tx_AbortFrame = (c == abort_at);
            Rst           = (c == rst_at);
            #1;
            cap_tx[c-1]  = Tx;
            cap_vld[c-1] = Tx_ValidFrame;
            cap_abt[c-1] = Tx_AbortedTrans;
            if (rst_at > 0 && c == rst_at + 1)
                cap_snap = {Tx, Tx_ValidFrame, Tx_Done, Tx_RdBuff,
                            Fcs_Clear, Fcs_Shift, Fcs_BitIn, Tx_AbortedTrans};
            if (Fcs_Shift) begin cap_sh[cap_shn] = Fcs_BitIn; cap_shn++; end
            if (Fcs_Clear) cap_clr++;
            if (Tx_Done) begin cap_done++; done_at = c; end
            if (Tx_RdBuff) begin
                if (ptr < 8) Tx_DataOutBuff = buf_mem[ptr];
                ptr++;
                cap_rd++;
            end
        end
        Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        Rst = 1'b1; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_DataAvail = 1'b1;
        Tx_FrameSize = 8'd0; Tx_DataOutBuff = 8'd0; Fcs_Value = 16'd0;
        repeat (3) @(negedge Clk);
        outs = {Tx, Tx_ValidFrame, Tx_Done, Tx_RdBuff, Fcs_Clear, Fcs_Shift, Fcs_BitIn, Tx_AbortedTrans};
        n_cmp++;
        if (outs !== 8'b1000_0000) begin n_bad++; $display("FAIL reset_outs: got %b want 10000000", outs); end
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: Tx=%b valid=%b want 1/0", Tx, Tx_ValidFrame);
        end
    endtask

    // Size 1, byte 00, FCS 0000; abort on the last closing-flag bit must be ignored.
    task automatic test_zero_frame();
        logic [47:0] exp_tx;
        exp_tx = {8'hFF, 8'h7E, 16'h0000, 8'h00, 8'h7E};
        buf_mem[0] = 8'h00; Fcs_Value = 16'h0000;
        run(1, 48, 40, 0, 0);
        n_cmp++; if (cap_tx[47:0] !== exp_tx) begin n_bad++; $display("FAIL zero_tx: got %h want %h", cap_tx[47:0], exp_tx); end
        n_cmp++; if (done_at !== 40 || cap_done !== 1) begin n_bad++; $display("FAIL zero_done: at %0d n %0d want 40/1", done_at, cap_done); end
        n_cmp++; if (cap_rd !== 1) begin n_bad++; $display("FAIL zero_rd: got %0d want 1", cap_rd); end
        n_cmp++; if (cap_shn !== 8 || cap_sh[7:0] !== 8'h00) begin n_bad++; $display("FAIL zero_shift: n %0d bits %h want 8/00", cap_shn, cap_sh[7:0]); end
        n_cmp++; if (cap_vld[47:0] !== 48'h00FF_FFFF_FFFF) begin n_bad++; $display("FAIL zero_valid: got %h want 00ffffffffff", cap_vld[47:0]); end
        n_cmp++; if (cap_clr !== 1 || cap_abt[47:0] !== 48'h0) begin n_bad++; $display("FAIL zero_clr_abt: clr %0d abt %h want 1/0", cap_clr, cap_abt[47:0]); end
    endtask

    // Byte FF: five ones then an inserted zero; a stray Tx_Enable mid-frame is ignored.
    task automatic test_stuff_data();
        logic [43:0] exp_tx;
        exp_tx = {3'b111, 8'h7E, 16'h0000, 9'h1DF, 8'h7E};
        buf_mem[0] = 8'hFF; Fcs_Value = 16'h0000;
        run(1, 44, 0, 20, 0);
        n_cmp++; if (cap_tx[43:0] !== exp_tx) begin n_bad++; $display("FAIL stuff_tx: got %h want %h", cap_tx[43:0], exp_tx); end
        n_cmp++; if (done_at !== 41 || cap_done !== 1) begin n_bad++; $display("FAIL stuff_done: at %0d n %0d want 41/1", done_at, cap_done); end
        n_cmp++; if (cap_shn !== 8 || cap_sh[7:0] !== 8'hFF) begin n_bad++; $display("FAIL stuff_shift: n %0d bits %h want 8/ff", cap_shn, cap_sh[7:0]); end
        n_cmp++; if (cap_vld[43:0] !== 44'h1FF_FFFF_FFFF) begin n_bad++; $display("FAIL stuff_valid: got %h want 1ffffffffff", cap_vld[43:0]); end
    endtask

    task automatic test_stuff_fcs();
        logic [43:0] exp_tx;
        exp_tx = {3'b111, 8'h7E, 17'h0001F, 8'h00, 8'h7E};
        buf_mem[0] = 8'h00; Fcs_Value = 16'h001F;
        run(1, 44, 0, 0, 0);
        n_cmp++; if (cap_tx[43:0] !== exp_tx) begin n_bad++; $display("FAIL fcs_tx: got %h want %h", cap_tx[43:0], exp_tx); end
        n_cmp++; if (done_at !== 41) begin n_bad++; $display("FAIL fcs_done: at %0d want 41", done_at); end
        n_cmp++; if (cap_shn !== 8) begin n_bad++; $display("FAIL fcs_shift: n %0d want 8", cap_shn); end
    endtask

    // Size 4, abort sampled during the second byte (cycle 19).
    task automatic test_abort();
        logic [29:0] exp_tx;
        exp_tx = {10'h3FF, 1'b0, 3'b100, 8'hA5, 8'h7E};
        buf_mem[0] = 8'hA5; buf_mem[1] = 8'h3C; buf_mem[2] = 8'h0F; buf_mem[3] = 8'h81;
        Fcs_Value = 16'h1234;
        run(4, 30, 19, 0, 0);
        n_cmp++; if (cap_tx[29:0] !== exp_tx) begin n_bad++; $display("FAIL abort_tx: got %h want %h", cap_tx[29:0], exp_tx); end
        n_cmp++; if (cap_vld[29:0] !== 30'h0007FFFF) begin n_bad++; $display("FAIL abort_valid: got %h want 0007ffff", cap_vld[29:0]); end
        n_cmp++; if (cap_abt[29:0] !== 30'h3FF80000) begin n_bad++; $display("FAIL abort_sticky: got %h want 3ff80000", cap_abt[29:0]); end
        n_cmp++; if (cap_done !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", cap_done); end
        n_cmp++; if (cap_rd !== 3) begin n_bad++; $display("FAIL abort_rd: got %0d want 3", cap_rd); end
        n_cmp++; if (cap_shn !== 11 || cap_sh[10:0] !== 11'h4A5) begin n_bad++; $display("FAIL abort_shift: n %0d bits %h want 11/4a5", cap_shn, cap_sh[10:0]); end
    endtask

    // Rejected starts leave the line idle and the sticky abort flag untouched.
    task automatic test_reject();
        int sizes [3];
        sizes = '{0, 129, 1};
        for (int k = 0; k < 3; k++) begin
            Tx_DataAvail = (k != 2);
            run(sizes[k], 12, 0, 0, 0);
            n_cmp++;
            if (cap_tx[11:0] !== 12'hFFF || cap_vld[11:0] !== 12'h000) begin
                n_bad++; $display("FAIL reject_line_%0d: tx %h valid %h want fff/000", k, cap_tx[11:0], cap_vld[11:0]);
            end
            n_cmp++;
            if (cap_rd !== 0 || cap_clr !== 0) begin
                n_bad++; $display("FAIL reject_strobes_%0d: rd %0d clr %0d want 0/0", k, cap_rd, cap_clr);
            end
            n_cmp++;
            if (cap_abt[11:0] !== 12'hFFF) begin
                n_bad++; $display("FAIL reject_sticky_%0d: got %h want fff", k, cap_abt[11:0]);
            end
        end
        Tx_DataAvail = 1'b1;
    endtask

    // Two-byte frame with stuffing across the byte boundary, then an immediate second frame.
    task automatic test_back_to_back();
        logic [48:0] exp_a;
        logic [39:0] exp_b;
        exp_a = {8'h7E, 16'h0000, 17'h005F0, 8'h7E};
        exp_b = {8'h7E, 16'h0000, 8'h00, 8'h7E};
        buf_mem[0] = 8'hF0; buf_mem[1] = 8'h03; Fcs_Value = 16'h0000;
        run(2, 49, 0, 0, 0);
        n_cmp++; if (cap_tx[48:0] !== exp_a) begin n_bad++; $display("FAIL b2b_a_tx: got %h want %h", cap_tx[48:0], exp_a); end
        n_cmp++; if (done_at !== 49 || cap_rd !== 2) begin n_bad++; $display("FAIL b2b_a_done_rd: at %0d rd %0d want 49/2", done_at, cap_rd); end
        n_cmp++; if (cap_shn !== 16 || cap_sh[15:0] !== 16'h03F0) begin n_bad++; $display("FAIL b2b_a_shift: n %0d bits %h want 16/03f0", cap_shn, cap_sh[15:0]); end
        n_cmp++; if (cap_abt[48:0] !== 49'h0) begin n_bad++; $display("FAIL b2b_a_sticky: got %h want 0", cap_abt[48:0]); end
        buf_mem[0] = 8'h00;
        run(1, 40, 0, 0, 0);
        n_cmp++; if (cap_tx[39:0] !== exp_b) begin n_bad++; $display("FAIL b2b_b_tx: got %h want %h", cap_tx[39:0], exp_b); end
        n_cmp++; if (done_at !== 40) begin n_bad++; $display("FAIL b2b_b_done: at %0d want 40", done_at); end
    endtask

    task automatic test_reset_mid_frame();
        logic [19:0] exp_tx;
        logic [39:0] exp_b;
        exp_tx = {8'hFF, 4'h0, 8'h7E};
        exp_b  = {8'h7E, 16'h0000, 8'h00, 8'h7E};
        buf_mem[0] = 8'h00; buf_mem[1] = 8'h00; Fcs_Value = 16'h0000;
        run(2, 20, 0, 0, 12);
        n_cmp++; if (cap_tx[19:0] !== exp_tx) begin n_bad++; $display("FAIL rst_tx: got %h want %h", cap_tx[19:0], exp_tx); end
        n_cmp++; if (cap_snap !== 8'b1000_0000) begin n_bad++; $display("FAIL rst_outs: got %b want 10000000", cap_snap); end
        n_cmp++; if (cap_vld[19:0] !== 20'h00FFF || cap_done !== 0) begin n_bad++; $display("FAIL rst_valid: got %h done %0d want 00fff/0", cap_vld[19:0], cap_done); end
        run(1, 40, 0, 0, 0);
        n_cmp++; if (cap_tx[39:0] !== exp_b || done_at !== 40) begin n_bad++; $display("FAIL rst_clean: got %h at %0d want %h/40", cap_tx[39:0], done_at, exp_b); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) buf_mem[i] = 8'h00;
        test_reset();
        test_zero_frame();
        test_stuff_data();
        test_stuff_fcs();
        test_abort();
        test_reject();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
